// File: rtl/hazard_unit.sv
// hazard_unit
//   Tuse/Tnew scoreboard hazard controller for the 5-stage MIPS pipeline.
//   Keeps a shadow {vld, dst, tnew} of the instructions in the E, M and W
//   stages and stalls the D instruction while a source operand is still
//   being produced. It also tracks an optional multi-cycle mult/div unit.
//
//   Build option: define HAZARD_MD_EN to compile in the mult/div busy
//   counter and its interlock. Without it MdBusy is 0 and the Md* inputs
//   are ignored.
//
// Ports
//   clk, reset                 core clock, synchronous active-high reset
//   RsD/RtD, UseRsD/UseRtD     D-stage source registers and their valid bits
//   TuseRsD/TuseRtD            cycles from D until each operand is consumed
//   RegWriteD/WriteRegD/TnewD  D-stage destination and its result latency
//   MdStartD/MdDivD/MdUseD     mult/div issue, divide select, unit-idle need
//   StallF/StallD/FlushE       hold PC, hold D register, bubble into E
//   MdBusy                     mult/div unit busy
module hazard_unit #(
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] RsD,
    input  logic [AW-1:0] RtD,
    input  logic          UseRsD,
    input  logic          UseRtD,
    input  logic [TW-1:0] TuseRsD,
    input  logic [TW-1:0] TuseRtD,
    input  logic          RegWriteD,
    input  logic [AW-1:0] WriteRegD,
    input  logic [TW-1:0] TnewD,
    input  logic          MdStartD,
    input  logic          MdDivD,
    input  logic          MdUseD,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushE,
    output logic          MdBusy
);

    // Shadow pipeline entries
    logic          e_vld_q, e_vld_d, m_vld_q, m_vld_d, w_vld_q, w_vld_d;
    logic [AW-1:0] e_dst_q, e_dst_d, m_dst_q, m_dst_d, w_dst_q, w_dst_d;
    logic [TW-1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;

    logic rs_hazard;
    logic rt_hazard;
    logic md_hazard;
    logic md_busy;
    logic stall_raw;

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Nearest matching stage decides. W is included for completeness; its
    // tnew is always 0 so it can never report a hazard.
    function automatic logic src_hazard(input logic          use_s,
                                        input logic [AW-1:0] src,
                                        input logic [TW-1:0] tuse);
        logic hz;
        hz = 1'b0;
        if (use_s && (src != '0)) begin
            if (e_vld_q && (e_dst_q == src))      hz = (e_tnew_q > tuse);
            else if (m_vld_q && (m_dst_q == src)) hz = (m_tnew_q > tuse);
            else if (w_vld_q && (w_dst_q == src)) hz = (w_tnew_q > tuse);
        end
        return hz;
    endfunction

    always_comb begin
        rs_hazard = src_hazard(UseRsD, RsD, TuseRsD);
        rt_hazard = src_hazard(UseRtD, RtD, TuseRtD);
        stall_raw = rs_hazard | rt_hazard | md_hazard;
    end

`ifdef HAZARD_MD_EN
    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [CW-1:0] mdcnt_q, mdcnt_d;

    always_comb begin
        md_busy   = (mdcnt_q != '0);
        md_hazard = MdUseD & md_busy;
    end

    // A stalled mult/div never issues, so it must not load the counter.
    always_comb begin
        mdcnt_d = mdcnt_q;
        if (MdStartD && !stall_raw)
            mdcnt_d = MdDivD ? CW'(DIV_CYC) : CW'(MULT_CYC);
        else if (mdcnt_q != '0)
            mdcnt_d = mdcnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) mdcnt_q <= '0;
        else       mdcnt_q <= mdcnt_d;
    end
`else
    logic unused_md;
    always_comb begin
        md_busy   = 1'b0;
        md_hazard = 1'b0;
        unused_md = MdStartD ^ MdDivD ^ MdUseD;
    end
`endif

    // Shadow advance: a stalled D instruction leaves a bubble in E.
    always_comb begin
        e_vld_d  = RegWriteD && (WriteRegD != '0) && !stall_raw;
        e_dst_d  = WriteRegD;
        e_tnew_d = TnewD;
        m_vld_d  = e_vld_q;
        m_dst_d  = e_dst_q;
        m_tnew_d = dec_sat(e_tnew_q);
        w_vld_d  = m_vld_q;
        w_dst_d  = m_dst_q;
        w_tnew_d = dec_sat(m_tnew_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_vld_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            w_vld_q  <= 1'b0;
            e_dst_q  <= '0;
            m_dst_q  <= '0;
            w_dst_q  <= '0;
            e_tnew_q <= '0;
            m_tnew_q <= '0;
            w_tnew_q <= '0;
        end else begin
            e_vld_q  <= e_vld_d;
            m_vld_q  <= m_vld_d;
            w_vld_q  <= w_vld_d;
            e_dst_q  <= e_dst_d;
            m_dst_q  <= m_dst_d;
            w_dst_q  <= w_dst_d;
            e_tnew_q <= e_tnew_d;
            m_tnew_q <= m_tnew_d;
            w_tnew_q <= w_tnew_d;
        end
    end

    // Outputs are held low while reset is asserted.
    always_comb begin
        StallF = stall_raw & ~reset;
        StallD = stall_raw & ~reset;
        FlushE = stall_raw & ~reset;
        MdBusy = md_busy & ~reset;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
//   Directed bench for hazard_unit: load-use, branch and store-data
//   latencies, $0 writes, nearest-producer priority, mult/div interlock
//   and reset behaviour. Expected outputs are hand-derived per step.
module tb_hazard_unit;

`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [4:0] RsD, RtD, WriteRegD;
    logic       UseRsD, UseRtD, RegWriteD;
    logic [1:0] TuseRsD, TuseRtD, TnewD;
    logic       MdStartD, MdDivD, MdUseD;
    logic       StallF, StallD, FlushE, MdBusy;

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_unit #(.AW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD),
        .TuseRsD(TuseRsD), .TuseRtD(TuseRtD),
        .RegWriteD(RegWriteD), .WriteRegD(WriteRegD), .TnewD(TnewD),
        .MdStartD(MdStartD), .MdDivD(MdDivD), .MdUseD(MdUseD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MdBusy(MdBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_nop();
        RsD = '0; RtD = '0; UseRsD = 0; UseRtD = 0; TuseRsD = '0; TuseRtD = '0;
        RegWriteD = 0; WriteRegD = '0; TnewD = '0;
        MdStartD = 0; MdDivD = 0; MdUseD = 0;
    endtask

    task automatic d_write(input logic [4:0] wr, input logic [1:0] tnew);
        d_nop();
        RegWriteD = 1; WriteRegD = wr; TnewD = tnew;
    endtask

    task automatic d_read(input logic [4:0] rs, input logic urs, input logic [1:0] trs,
                          input logic [4:0] rt, input logic urt, input logic [1:0] trt);
        d_nop();
        RsD = rs; UseRsD = urs; TuseRsD = trs;
        RtD = rt; UseRtD = urt; TuseRtD = trt;
    endtask

    task automatic d_md(input logic start, input logic div, input logic use_u);
        d_nop();
        MdStartD = start; MdDivD = div; MdUseD = use_u;
    endtask

    task automatic drain(input int n);
        d_nop();
        for (int i = 0; i < n; i++) tick();
    endtask

    // Observed vector is {StallF, StallD, FlushE, MdBusy}.
    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        #1;
        obs = {StallF, StallD, FlushE, MdBusy};
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        d_read(5'd1, 1, 2'd0, 5'd0, 0, 2'd0);
        MdUseD = 1;
        tick();
        check("rst_outputs", 4'b0000);
        tick();
        reset = 1'b0;
        d_nop();
        check("post_reset", 4'b0000);

        // lw $1 ; addu $3,$1,$2 -> one stall cycle
        d_write(5'd1, 2'd2);
        check("lw_issue", 4'b0000);
        tick();
        d_read(5'd1, 1, 2'd1, 5'd2, 1, 2'd1);
        RegWriteD = 1; WriteRegD = 5'd3; TnewD = 2'd1;
        check("load_use_stall", 4'b1110);
        tick();
        check("load_use_go", 4'b0000);
        tick();
        drain(3);

        // addu $1 ; beq $1 -> one stall cycle
        d_write(5'd1, 2'd1);
        tick();
        d_read(5'd1, 1, 2'd0, 5'd0, 1, 2'd0);
        check("alu_beq_stall", 4'b1110);
        tick();
        check("alu_beq_go", 4'b0000);
        drain(3);

        // lw $1 ; beq $1,$1 -> two stall cycles
        d_write(5'd1, 2'd2);
        tick();
        d_read(5'd1, 1, 2'd0, 5'd1, 1, 2'd0);
        check("lw_beq_stall1", 4'b1110);
        tick();
        check("lw_beq_stall2", 4'b1110);
        tick();
        check("lw_beq_go", 4'b0000);
        drain(3);

        // lw $1 ; sw $1 as store data -> no stall
        d_write(5'd1, 2'd2);
        tick();
        d_read(5'd5, 1, 2'd1, 5'd1, 1, 2'd2);
        check("lw_sw_data", 4'b0000);
        drain(3);

        // writes to $0 never create a hazard
        d_write(5'd0, 2'd2);
        tick();
        d_read(5'd0, 1, 2'd0, 5'd0, 1, 2'd0);
        check("zero_reg_e", 4'b0000);
        tick();
        check("zero_reg_m", 4'b0000);
        drain(3);

        // E ($2, tnew 0) shadows M ($2, tnew 1)
        d_write(5'd2, 2'd2);
        tick();
        d_write(5'd2, 2'd0);
        check("near_setup", 4'b0000);
        tick();
        d_read(5'd2, 1, 2'd0, 5'd0, 0, 2'd0);
        check("near_e_decides", 4'b0000);
        drain(3);

        // E writes another reg, M still producing $2 -> stall from M
        d_write(5'd2, 2'd2);
        tick();
        d_write(5'd7, 2'd1);
        check("far_setup", 4'b0000);
        tick();
        d_read(5'd2, 1, 2'd0, 5'd0, 0, 2'd0);
        check("far_m_stall", 4'b1110);
        tick();
        check("far_m_go", 4'b0000);
        drain(3);

        // rt source: ignored unless UseRtD
        d_write(5'd4, 2'd1);
        tick();
        d_read(5'd9, 1, 2'd0, 5'd4, 0, 2'd0);
        check("rt_unused", 4'b0000);
        d_read(5'd9, 1, 2'd0, 5'd4, 1, 2'd0);
        check("rt_hazard", 4'b1110);
        tick();
        check("rt_go", 4'b0000);
        drain(3);

        // mult then mfhi
        d_md(1, 0, 1);
        check("mult_issue", 4'b0000);
        tick();
        d_md(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("mfhi_wait", MD_EN ? 4'b1111 : 4'b0000);
            tick();
        end
        check("mfhi_go", 4'b0000);
        drain(2);

        // div then mfhi
        d_md(1, 1, 1);
        check("div_issue", 4'b0000);
        tick();
        d_md(0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            check("mflo_wait", MD_EN ? 4'b1111 : 4'b0000);
            tick();
        end
        check("mflo_go", 4'b0000);
        drain(2);

        // mult stalled by a register hazard must not load the counter
        d_write(5'd1, 2'd2);
        tick();
        d_read(5'd1, 1, 2'd1, 5'd0, 0, 2'd0);
        MdStartD = 1; MdUseD = 1;
        check("md_vs_reg", 4'b1110);
        tick();
        check("md_no_load", 4'b0000);
        tick();
        d_nop();
        check("md_load_late", {3'b000, MD_EN});
        drain(6);

        // reset mid-divide with a load in E
        d_md(1, 1, 1);
        tick();
        d_nop();
        tick();
        tick();
        d_write(5'd1, 2'd2);
        tick();
        d_read(5'd1, 1, 2'd0, 5'd0, 0, 2'd0);
        MdUseD = 1;
        check("pre_reset", {3'b111, MD_EN});
        reset = 1'b1;
        check("reset_force", 4'b0000);
        tick();
        check("reset_hold", 4'b0000);
        reset = 1'b0;
        check("reset_cleared", 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
